// File: rtl/game_pkg.sv
// Shared keycodes, charge FSM states and power constants for the throw path.
package game_pkg;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    localparam int unsigned MAX_POWER = 255;
    localparam int unsigned MIN_POWER = 8;

    localparam int unsigned TICK_DIV_DEFAULT        = 254_902;
    localparam int unsigned COOLDOWN_CYCLES_DEFAULT = 6_500_000;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        FIRE,
        COOLDOWN
    } charge_state_t;

    // Raise a released power value to the minimum throw strength.
    function automatic logic [7:0] floor_power(input logic [7:0] p, input logic [7:0] min_p);
        return (p < min_p) ? min_p : p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Charge-rate divider: pulses tick once every DIV cycles while clr is low.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    // Count 0..DIV-1, wrapping on tick; held at zero while cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/space_charge_ctl.sv
// SPACE-key charge controller: hold to build power, release to throw.
module space_charge_ctl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV        = game_pkg::TICK_DIV_DEFAULT,
    parameter int unsigned MAX_POWER       = game_pkg::MAX_POWER,
    parameter int unsigned MIN_POWER       = game_pkg::MIN_POWER,
    parameter int unsigned COOLDOWN_CYCLES = game_pkg::COOLDOWN_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        key_valid,
    input  logic        enable,
    output logic        charging,
    output logic [7:0]  power_level,
    output logic        throw_trigger,
    output logic [7:0]  throw_power,
    output logic        busy
);

    localparam int unsigned CDW = $clog2(COOLDOWN_CYCLES + 1);

    charge_state_t state_q, state_d;
    logic [7:0]     power_q, power_d;
    logic [7:0]     throw_power_q, throw_power_d;
    logic [CDW-1:0] cool_q, cool_d;
    logic           charging_q, charging_d;
    logic           trig_q, trig_d;
    logic           busy_q, busy_d;

    logic       tick;
    logic       tick_clr;
    logic       is_make;
    logic       is_break;
    logic [7:0] power_inc;

    assign tick_clr = (state_q != CHARGE);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Keycode decode; a make preceded by F0 is a break, not a repeat.
    assign is_make  = key_valid && (keycode[7:0] == KEY_SPACE) && (keycode[15:8] != KEY_BREAK);
    assign is_break = key_valid && (keycode == {KEY_BREAK, KEY_SPACE});

    // Power after this cycle's tick, saturating at MAX_POWER.
    assign power_inc = (tick && (power_q < 8'(MAX_POWER))) ? power_q + 8'd1 : power_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        power_d       = power_q;
        throw_power_d = throw_power_q;
        cool_d        = cool_q;
        case (state_q)
            IDLE: begin
                if (is_make && enable) begin
                    state_d = CHARGE;
                    power_d = 8'd0;
                end
            end
            CHARGE: begin
                if (!enable) begin
                    state_d = IDLE;
                    power_d = 8'd0;
                end else if (is_break) begin
                    state_d       = FIRE;
                    power_d       = power_inc;
                    throw_power_d = floor_power(power_inc, 8'(MIN_POWER));
                end else begin
                    power_d = power_inc;
                end
            end
            FIRE: begin
                state_d = COOLDOWN;
                power_d = 8'd0;
                cool_d  = '0;
            end
            COOLDOWN: begin
                if (cool_q == CDW'(COOLDOWN_CYCLES - 1)) begin
                    state_d = IDLE;
                    cool_d  = '0;
                end else begin
                    cool_d = cool_q + CDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                power_d = 8'd0;
                cool_d  = '0;
            end
        endcase
        charging_d = (state_d == CHARGE);
        trig_d     = (state_d == FIRE);
        busy_d     = (state_d != IDLE);
    end

    // State, counters and outputs; reset aborts any charge without a trigger.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            power_q       <= 8'd0;
            throw_power_q <= 8'd0;
            cool_q        <= '0;
            charging_q    <= 1'b0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            power_q       <= power_d;
            throw_power_q <= throw_power_d;
            cool_q        <= cool_d;
            charging_q    <= charging_d;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
        end
    end

    assign charging      = charging_q;
    assign power_level   = power_q;
    assign throw_trigger = trig_q;
    assign throw_power   = throw_power_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_space_charge_ctl.sv
// Self-checking bench for space_charge_ctl with a behavioural charge model.
module tb_space_charge_ctl;

    localparam int TD   = 4;
    localparam int CD   = 16;
    localparam int MINP = 8;
    localparam int MAXP = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keycode;
    logic        key_valid;
    logic        enable;
    logic        charging;
    logic [7:0]  power_level;
    logic        throw_trigger;
    logic [7:0]  throw_power;
    logic        busy;

    always #5 clk = ~clk;

    space_charge_ctl #(
        .TICK_DIV        (TD),
        .MAX_POWER       (MAXP),
        .MIN_POWER       (MINP),
        .COOLDOWN_CYCLES (CD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .keycode       (keycode),
        .key_valid     (key_valid),
        .enable        (enable),
        .charging      (charging),
        .power_level   (power_level),
        .throw_trigger (throw_trigger),
        .throw_power   (throw_power),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int trig_cnt = 0;
    bit cmp_en   = 1'b0;

    // Model: held = cycles spent charging; power is held/TD capped at MAXP.
    typedef struct packed {
        logic chg;
        logic fire;
        int   held;
        int   cool_left;
        int   level;
        int   tp;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_step(mstate_t s, logic r, logic kv, logic [15:0] kc, logic en);
        mstate_t n = s;
        logic mk  = kv && (kc[7:0] == 8'h29) && (kc[15:8] != 8'hF0);
        logic brk = kv && (kc == 16'hF029);
        if (!r) begin
            n = '0;
        end else if (s.chg) begin
            n.held = s.held + 1;
            if (!en) begin
                n.chg   = 1'b0;
                n.level = 0;
            end else begin
                n.level = (n.held / TD > MAXP) ? MAXP : n.held / TD;
                if (brk) begin
                    n.chg  = 1'b0;
                    n.fire = 1'b1;
                    n.tp   = (n.level < MINP) ? MINP : n.level;
                end
            end
        end else if (s.fire) begin
            n.fire      = 1'b0;
            n.cool_left = CD;
            n.level     = 0;
        end else if (s.cool_left > 0) begin
            n.cool_left = s.cool_left - 1;
        end else if (mk && en) begin
            n.chg   = 1'b1;
            n.held  = 0;
            n.level = 0;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, rst, key_valid, keycode, enable);

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("charging", int'(charging), int'(m.chg));
            chk("power_level", int'(power_level), m.level);
            chk("throw_trigger", int'(throw_trigger), int'(m.fire));
            chk("throw_power", int'(throw_power), m.tp);
            chk("busy", int'(busy), int'(m.chg || m.fire || (m.cool_left > 0)));
            if (throw_trigger) trig_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] c);
        keycode   = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, int'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 5000000", $time);
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        logic [15:0] codes [6];
        rst       = 1'b0;
        key_valid = 1'b0;
        keycode   = 16'h0000;
        enable    = 1'b0;
        cycles(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_power", int'(power_level), 0);
        cmp_en = 1'b1;
        rst    = 1'b1;
        enable = 1'b1;
        cycles(2);

        // Normal throw: break sampled 200 cycles after the make.
        strobe(16'h0029);
        chk("make_charging", int'(charging), 1);
        cycles(199);
        t0 = trig_cnt;
        strobe(16'hF029);
        chk("normal_trigger", int'(throw_trigger), 1);
        chk("normal_tp", int'(throw_power), 50);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("normal_busy_len", n, 17);
        chk("normal_trig_count", trig_cnt, t0 + 1);

        // Short press: floor applied to the released power.
        strobe(16'h0029);
        cycles(7);
        strobe(16'hF029);
        chk("short_level", int'(power_level), 2);
        chk("short_tp", int'(throw_power), 8);
        wait_idle("short_idle");

        // Saturation with typematic repeats.
        strobe(16'h0029);
        repeat (12) begin
            cycles(99);
            strobe(16'h0029);
        end
        cycles(5);
        chk("sat_level", int'(power_level), 255);
        strobe(16'hF029);
        chk("sat_tp", int'(throw_power), 255);
        wait_idle("sat_idle");

        // Abort by dropping enable, then abort winning over a same-cycle break.
        t0 = trig_cnt;
        strobe(16'h0029);
        cycles(39);
        enable = 1'b0;
        cycles(1);
        enable = 1'b1;
        chk("abort_charging", int'(charging), 0);
        chk("abort_power", int'(power_level), 0);
        chk("abort_busy", int'(busy), 0);
        strobe(16'h0029);
        cycles(39);
        enable = 1'b0;
        strobe(16'hF029);
        enable = 1'b1;
        chk("abort2_trigger", int'(throw_trigger), 0);
        chk("abort2_busy", int'(busy), 0);
        cycles(3);
        chk("abort_trig_count", trig_cnt, t0);

        // Reset in the middle of a charge.
        strobe(16'h0029);
        cycles(40);
        rst = 1'b0;
        cycles(3);
        chk("midrst_charging", int'(charging), 0);
        chk("midrst_power", int'(power_level), 0);
        chk("midrst_tp", int'(throw_power), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b1;
        cycles(20);
        chk("midrst_trig_count", trig_cnt, t0);

        // Cooldown drops makes; other codes and idle breaks are ignored.
        strobe(16'h0029);
        cycles(20);
        t0 = trig_cnt;
        strobe(16'hF029);
        cycles(2);
        strobe(16'h0029);
        cycles(2);
        chk("cool_make_dropped", int'(charging), 0);
        wait_idle("cool_idle");
        strobe(16'h001C);
        strobe(16'hF029);
        cycles(2);
        chk("filter_charging", int'(charging), 0);
        chk("filter_trig_count", trig_cnt, t0 + 1);
        strobe(16'h0029);
        chk("post_cool_make", int'(charging), 1);
        cycles(10);
        strobe(16'hF029);
        wait_idle("post_cool_idle");

        // Randomized traffic checked against the model every cycle.
        codes[0] = 16'h0029;
        codes[1] = 16'hF029;
        codes[2] = 16'h2929;
        codes[3] = 16'h001C;
        codes[4] = 16'hF01C;
        for (int i = 0; i < 6000; i++) begin
            codes[5]  = 16'($urandom);
            key_valid = ($urandom_range(0, 29) == 0);
            keycode   = codes[$urandom_range(0, 5)];
            enable    = ($urandom_range(0, 399) != 0);
            rst       = ($urandom_range(0, 2999) != 0);
            @(negedge clk);
        end
        key_valid = 1'b0;
        rst       = 1'b1;
        enable    = 1'b1;
        cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
